// File: rtl/systolic_out_buff.sv
// systolic_out_buff
//   Result-side frame buffer between the systolic tile's south edge and the
//   DMA write channel. One frame of result words (1..2^ADDR_WIDTH) is written
//   in FILL, then replayed in order to the DMA engine in DRAIN. The two phases
//   never overlap, so the RAM never sees a same-address read/write race.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   res_valid    tile presents res_data (res_last marks the final word)
//   res_ready    buffer accepts the result word this cycle
//   res_data     result word
//   res_last     last word of the frame, qualified by res_valid
//   out_valid    word available to DMA
//   out_ready    DMA accepts the word
//   out_data     offered word
//   out_addr     0-based index of the offered word within the frame
//   out_last     offered word is the last of the frame
//   frame_words  word count of the current/last frame
//   frame_done   one-cycle pulse after the last word is accepted
//   dbg_state    FSM state (0 = FILL, 1 = DRAIN)
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both 1. Once out_valid is raised, out_data/out_addr/out_last are held
// unchanged until the transfer happens; out_valid is never withdrawn.

module systolic_out_buff #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DMA_DATA_WIDTH = 32,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [DMA_DATA_WIDTH-1:0] res_data,
  input  logic                      res_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DMA_DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic                      out_last,
  output logic [ADDR_WIDTH:0]       frame_words,
  output logic                      frame_done,
  output logic                      dbg_state
);

  localparam int                  DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

  localparam logic [0:0] S_FILL  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  // Result words carry whole packed elements; no repacking happens here.
  if (DMA_DATA_WIDTH % DATA_WIDTH != 0) begin : g_bad_width
    $error("DMA_DATA_WIDTH must be a multiple of DATA_WIDTH");
  end

  logic [0:0]                state_q, state_d;
  logic                      ready_en_q;
  logic [ADDR_WIDTH:0]       wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH:0]       frame_words_q, frame_words_d;
  logic [ADDR_WIDTH:0]       rd_idx_q, rd_idx_d;
  // Stage 1: RAM output register and the index it holds.
  logic                      s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0]     s1_idx_q, s1_idx_d;
  // Stage 2: holding register that drives the DMA side.
  logic                      out_valid_q, out_valid_d;
  logic [DMA_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0]     out_addr_q, out_addr_d;
  logic                      out_last_q, out_last_d;
  logic                      frame_done_q, frame_done_d;

  logic [DMA_DATA_WIDTH-1:0] mem [DEPTH];
  logic [DMA_DATA_WIDTH-1:0] ram_dout_q;

  logic wr_fire, rd_en, s2_load, out_fire, drain_end;

  // ready_en_q keeps res_ready low while reset is held and for the reset
  // cycle itself; it rises on the first clock after release.
  assign res_ready = ready_en_q && (state_q == S_FILL) && (wr_cnt_q < DEPTH_C);
  assign wr_fire   = res_valid && res_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign drain_end = out_fire && out_last_q;
  // Stage 2 takes stage 1 when it is empty or being emptied this cycle.
  assign s2_load   = s1_valid_q && (!out_valid_q || out_ready);
  // A new RAM read is issued only when stage 1 is free or moving on, so the
  // RAM output register doubles as the skid slot and is never overwritten.
  assign rd_en     = (state_q == S_DRAIN) && (rd_idx_q < frame_words_q) &&
                     (!s1_valid_q || s2_load);

  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    frame_words_d = frame_words_q;
    rd_idx_d      = rd_idx_q;
    s1_valid_d    = s1_valid_q;
    s1_idx_d      = s1_idx_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_addr_d    = out_addr_q;
    out_last_d    = out_last_q;
    frame_done_d  = drain_end;

    case (state_q)
      S_FILL: begin
        if (wr_fire) begin
          wr_cnt_d = wr_cnt_q + ONE;
          // Explicit last and running out of room close the frame the same
          // way; both at once is still a single close.
          if (res_last || (wr_cnt_q + ONE == DEPTH_C)) begin
            frame_words_d = wr_cnt_q + ONE;
            rd_idx_d      = '0;
            state_d       = S_DRAIN;
          end
        end
      end
      default: begin
        if (rd_en) rd_idx_d = rd_idx_q + ONE;
        if (drain_end) begin
          state_d  = S_FILL;
          wr_cnt_d = '0;
          rd_idx_d = '0;
        end
      end
    endcase

    if (rd_en) begin
      s1_valid_d = 1'b1;
      s1_idx_d   = rd_idx_q[ADDR_WIDTH-1:0];
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      out_valid_d = 1'b1;
      out_data_d  = ram_dout_q;
      out_addr_d  = s1_idx_q;
      out_last_d  = ({1'b0, s1_idx_q} + ONE) == frame_words_q;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_FILL;
      ready_en_q    <= 1'b0;
      wr_cnt_q      <= '0;
      frame_words_q <= '0;
      rd_idx_q      <= '0;
      s1_valid_q    <= 1'b0;
      s1_idx_q      <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_addr_q    <= '0;
      out_last_q    <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_en_q    <= 1'b1;
      wr_cnt_q      <= wr_cnt_d;
      frame_words_q <= frame_words_d;
      rd_idx_q      <= rd_idx_d;
      s1_valid_q    <= s1_valid_d;
      s1_idx_q      <= s1_idx_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_addr_q    <= out_addr_d;
      out_last_q    <= out_last_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Plain dual-port RAM with registered read; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_cnt_q[ADDR_WIDTH-1:0]] <= res_data;
    if (rd_en)   ram_dout_q <= mem[rd_idx_q[ADDR_WIDTH-1:0]];
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_addr    = out_addr_q;
  assign out_last    = out_last_q;
  assign frame_words = frame_words_q;
  assign frame_done  = frame_done_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/systolic_out_buff.md
# systolic_out_buff

Result-side buffer between the systolic tile's south edge and the DMA write channel. Collects one frame of packed result words (up to 2^ADDR_WIDTH), then drains them in order to the DMA engine with a valid/ready handshake, a word index, and a last marker. Single-buffered: fill and drain phases alternate. Mirrors the input buffer's DMA→mem→tile path in the tile→mem→DMA direction.

## Interface
- ADDR_WIDTH, 5: log2 of buffer depth; DEPTH = 2^ADDR_WIDTH = 32 words.
- DMA_DATA_WIDTH, 32: width of result and DMA words.
- DATA_WIDTH, 8: element width packed into a word (DMA_DATA_WIDTH/DATA_WIDTH elements per word); informational only, no repacking done here.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- res_valid  in  1  tile presents a result word.
- res_ready  out  1  buffer accepts the word this cycle.
- res_data  in  DMA_DATA_WIDTH  result word.
- res_last  in  1  final word of the frame, qualified by res_valid.
- out_valid  out  1  word available to DMA.
- out_ready  in  1  DMA accepts the word.
- out_data  out  DMA_DATA_WIDTH  word being offered.
- out_addr  out  ADDR_WIDTH  index of offered word within frame (0-based).
- out_last  out  1  offered word is last of frame.
- frame_words  out  ADDR_WIDTH+1  word count of current/last frame (1..DEPTH).
- frame_done  out  1  one-cycle pulse after last word is accepted by DMA.

## Operation
- Storage: DEPTH x DMA_DATA_WIDTH dual-port RAM, synchronous read (1-cycle latency), one write port, one read port.
- States: FILL, DRAIN. Reset → FILL.
- FILL: res_ready = 1 while wr_cnt < DEPTH. A transfer (res_valid & res_ready) writes res_data at address wr_cnt, wr_cnt += 1.
  - Transfer with res_last=1, or transfer that makes wr_cnt = DEPTH: frame closes; frame_words ← new wr_cnt; next state DRAIN; res_ready = 0 from next cycle.
  - Frame of DEPTH words with res_last=1 on word DEPTH-1: single close, no error.
- DRAIN: read words 0..frame_words-1 in order. out_addr = index of word on out_data; out_last = (out_addr == frame_words-1).
  - DMA transfer (out_valid & out_ready) advances to next index; accepting the last word → frame_done pulses next cycle, wr_cnt ← 0, state ← FILL.
  - res_ready = 0 throughout DRAIN; res_valid ignored.
- Prefetch: a skid/holding register behind the RAM read so out_data/out_addr/out_last stay stable while out_valid=1 and out_ready=0, and sustained out_ready=1 gives one word per cycle.
- Counters: wr_cnt and frame_words ADDR_WIDTH+1 bits (reach DEPTH); read index ADDR_WIDTH+1 bits internally, out_addr = low ADDR_WIDTH bits.
- Reset mid-frame (either state): contents discarded, counters 0, state FILL.

## Timing
- Reset values (while rst=0 and first cycle after): res_ready=0 during reset, 1 after; out_valid=0, out_data=0, out_addr=0, out_last=0, frame_words=0, frame_done=0.
- Closing transfer at edge T → state DRAIN from T; RAM read of word 0 issued cycle after T; out_valid=1 with word 0 two cycles after closing edge.
- Once out_valid=1, it stays 1 with stable data until accepted (no retraction).
- out_ready held 1: word k accepted on consecutive cycles, no bubbles.
- Last word accepted at edge E → out_valid=0 and frame_done=1 in cycle after E; res_ready=1 in the same cycle (new frame accepted immediately).
- Write-to-read hazard impossible (phases disjoint).

## Test plan
- Reset: hold rst=0 3 cycles with res_valid=1 → res_ready=0, out_valid=0, all outputs 0; release → res_ready=1 next cycle.
- Short frame: write 4 words 0xA0..0xA3, res_last on 0xA3, out_ready=1 → out_data 0xA0..0xA3 on 4 consecutive cycles, out_addr 0..3, out_last only on 0xA3, frame_words=4, one frame_done pulse.
- Full frame: 32 words, no res_last → frame closes at 32, res_ready drops, frame_words=32, out_last on out_addr=31; 33rd res_valid stalled until frame_done.
- Backpressure: 8-word frame, out_ready toggled 1,0,0,1,... random → every word delivered exactly once, in order, data/addr/last stable while stalled.
- Single-word frame: res_last on first word 0xDEAD → one DMA beat, out_addr=0, out_last=1, frame_words=1.
- Reset mid-drain: assert rst after word 2 of 6 accepted → out_valid=0 immediately; next frame of 3 words drains correctly from out_addr=0.
